jpc_pc: RTL and testbench
=========================

// Module: jpc_pc
// PURPOSE
//   Program counter register for the JPC core fetch stage.
//   Holds the current instruction address and presents it on pc_O.
//   Loads the next-PC value from the next-PC mux when enabled; holds its value when stalled.
//   Next-PC selection (sequential +4, branch, jump) is done upstream; this block only registers it.
// PARAMETERS
//   JPC_ADDRESS_WIDTH  32  width of PC and next-PC in bits (from jpc_config.v when defined)
//   JPC_RESET_VECTOR   0   value loaded into PC on reset; width JPC_ADDRESS_WIDTH
// PORTS
//   clk        input   1                  core clock; all state updates on rising edge
//   rst        input   1                  asynchronous reset, active-low (0 = reset asserted)
//   next_pc_I  input   JPC_ADDRESS_WIDTH  address to load on the next enabled clock edge
//   en_I       input   1                  PC update enable; 1 = load next_pc_I, 0 = stall/hold
//   pc_O       output  JPC_ADDRESS_WIDTH  current program counter, driven directly from the register
// BEHAVIOUR
//   - Single register pc_q of JPC_ADDRESS_WIDTH bits; pc_O = pc_q.
//     No combinational path from any input to pc_O.
//   - Reset
//     - rst low forces pc_q = JPC_RESET_VECTOR immediately, without waiting for a clock edge.
//     - The register holds that value for as long as rst stays low, regardless of clk, en_I and next_pc_I.
//   - Reset release
//     - First possible update is the first rising clk edge at which rst is high.
//     - On that edge en_I and next_pc_I are sampled normally.
//   - Normal operation (rst high, rising clk edge)
//     - en_I = 1: pc_q <= next_pc_I. Latency is 1 cycle; the new value is visible on pc_O right after the edge.
//     - en_I = 0: pc_q holds its value; next_pc_I is ignored (stall).
//   - Loaded values
//     - next_pc_I is loaded verbatim: no alignment masking, no increment, no sign or width conversion.
//     - Any value from 0 to 2^JPC_ADDRESS_WIDTH-1 is legal, including all-ones.
//     - Wrap-around is the upstream adder's concern; this block stores whatever it is given.
//   - Edge cases
//     - Stall may last any number of cycles; the value is held indefinitely.
//     - Reset asserted mid-operation: pc_O returns to JPC_RESET_VECTOR asynchronously, even while en_I = 1.
//     - Reset asserted during a stall: same asynchronous return to JPC_RESET_VECTOR.
//     - Reset wins over enable when both are active.
//     - en_I toggling with no clock edge has no effect.
//     - next_pc_I may change every cycle; only the value present at an enabled rising edge matters.
//   - Synthesizable: one always block, sensitive to posedge clk and negedge rst.
//   - No latches, no additional state.
// TESTING
//   1. Hold rst=0 for 25 ns, then release with en_I=1.
//      -> pc_O = 0 both during reset and just after release.
//   2. en_I=1, next_pc_I = pc_O+4 = 4, one clock period.
//      -> pc_O = 32'h4.
//   3. en_I=1, next_pc_I = 32'h100 (branch), one clock period.
//      -> pc_O = 32'h100.
//   4. en_I=0, next_pc_I = 32'h104, two clock periods.
//      -> pc_O stays 32'h100 (stall).
//   5. en_I=1, next_pc_I = 32'h104, one clock period.
//      -> pc_O = 32'h104 (resume).
//   6. With pc_O = 32'h104 and en_I=1, pulse rst low between clock edges.
//      -> pc_O = 0 immediately, before any clock edge.
//      -> Next enabled edge after release loads next_pc_I.
//      -> Also load 32'hFFFF_FFFF and check it is stored exactly.

Source files
------------

// File: rtl/jpc_pc.sv
`default_nettype none
// ============================================================================
//  Module   : jpc_pc
//  Purpose  : Program counter register for the JPC fetch stage. Loads the
//             upstream next-PC value on enabled clock edges, holds it while
//             stalled, and returns to the reset vector asynchronously.
//  Revision : 1.0 - initial release
// ============================================================================
module jpc_pc #(
  parameter int unsigned                   JPC_ADDRESS_WIDTH = 32,
  parameter logic [JPC_ADDRESS_WIDTH-1:0]  JPC_RESET_VECTOR  = '0
) (
  input  logic                          clk,
  input  logic                          rst,        // active-low, asynchronous
  input  logic [JPC_ADDRESS_WIDTH-1:0]  next_pc_I,
  input  logic                          en_I,
  output logic [JPC_ADDRESS_WIDTH-1:0]  pc_O
);

  logic [JPC_ADDRESS_WIDTH-1:0] pc_q;

  // PC register: async return to the reset vector, otherwise load when enabled.
  // The value is stored verbatim; alignment and wrap are handled upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= JPC_RESET_VECTOR;
    end else if (en_I) begin
      pc_q <= next_pc_I;
    end
  end

  assign pc_O = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_jpc_pc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jpc_pc
//  Purpose  : Scoreboard bench for jpc_pc. The driver pushes the expected PC
//             for every observation point (each rising clk edge and each
//             falling rst edge); the monitor pops and compares independently.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jpc_pc;

  localparam int unsigned      W  = 32;
  localparam logic [W-1:0]     RV = '0;

  logic          clk;
  logic          rst;
  logic [W-1:0]  next_pc_I;
  logic          en_I;
  logic [W-1:0]  pc_O;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  model_pc;
  bit            armed;
  int            checks;
  int            errors;

  jpc_pc #(
    .JPC_ADDRESS_WIDTH (W),
    .JPC_RESET_VECTOR  (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .next_pc_I (next_pc_I),
    .en_I      (en_I),
    .pc_O      (pc_O)
  );

  // 10 ns clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every rising clk edge and every reset assertion is an
  // observation point; sample 1 ns later and compare with the scoreboard.
  always @(posedge clk or negedge rst) begin
    if (armed) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: observation with no expectation, pc_O=%08h", pc_O);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (pc_O !== e) begin
          errors++;
          $display("FAIL pc: t=%0t pc_O=%08h expected=%08h", $time, pc_O, e);
        end
      end
    end
  end

  // One cycle of stimulus, issued at a falling clk edge.
  // rmode: 0 = run, 1 = reset held low through the next rising edge,
  //        2 = short reset pulse that ends before the next rising edge.
  task automatic drive_cycle(input int rmode, input bit en, input logic [W-1:0] nxt,
                             input bit glitch);
    if (rmode != 0 && rst === 1'b1) begin
      exp_q.push_back(RV);          // asynchronous effect of the falling edge
      rst = 1'b0;
    end else if (rmode == 0) begin
      rst = 1'b1;
    end
    en_I      = en;
    next_pc_I = nxt;
    if (rmode == 2) begin
      #2 rst = 1'b1;
    end
    // Reference: reset wins; otherwise enabled edge loads, disabled edge holds.
    if (rmode == 1)  model_pc = RV;
    else if (rmode == 2) model_pc = en ? nxt : RV;
    else if (en)     model_pc = nxt;
    exp_q.push_back(model_pc);
    if (glitch && rmode == 0) begin
      // Input activity between edges must leave the register untouched.
      #1 en_I = ~en; next_pc_I = ~nxt;
      #1 en_I = en;  next_pc_I = nxt;
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    armed     = 1'b0;
    model_pc  = RV;
    rst       = 1'b0;
    en_I      = 1'b1;
    next_pc_I = 32'h0;

    @(negedge clk);
    armed = 1'b1;

    // Reset held across clock edges with enable active, then release.
    drive_cycle(1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drive_cycle(1, 1'b1, 32'h1234_5678, 1'b0);
    drive_cycle(0, 1'b1, 32'h0000_0000, 1'b0);
    // Sequential, branch, stall, resume.
    drive_cycle(0, 1'b1, 32'h0000_0004, 1'b0);
    drive_cycle(0, 1'b1, 32'h0000_0100, 1'b0);
    drive_cycle(0, 1'b0, 32'h0000_0104, 1'b0);
    drive_cycle(0, 1'b0, 32'h0000_0104, 1'b1);
    drive_cycle(0, 1'b1, 32'h0000_0104, 1'b0);
    // Short reset pulse between edges while enabled, then next edge loads.
    drive_cycle(2, 1'b1, 32'h0000_0200, 1'b0);
    // All-ones stored exactly, then held through a stall.
    drive_cycle(0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    drive_cycle(0, 1'b0, 32'h0000_0000, 1'b1);
    // Reset during a stall.
    drive_cycle(1, 1'b0, 32'h0000_0300, 1'b0);
    drive_cycle(0, 1'b0, 32'h0000_0300, 1'b0);
    drive_cycle(0, 1'b1, 32'h0000_0300, 1'b0);

    // Randomized traffic with occasional resets and corner values.
    for (int i = 0; i < 400; i++) begin
      int            r;
      int            sel;
      logic [W-1:0]  nxt;
      bit            en;
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 9);
      nxt = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : W'($urandom);
      en  = ($urandom_range(0, 9) < 7);
      if (r < 3)       drive_cycle(1, en, nxt, 1'b0);
      else if (r < 6)  drive_cycle(2, en, nxt, 1'b0);
      else             drive_cycle(0, en, nxt, ($urandom_range(0, 4) == 0));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
